// File: rtl/module_conv.sv
// 3x3 fixed-kernel convolution over a serially loaded 8x8 signed Q1.7 frame.
// Loads 64 pixels row-major, then streams the 6x6 valid-region results, one per cycle.
module module_conv #(
    parameter logic signed [7:0] K0 = 8'sd14,
    parameter logic signed [7:0] K1 = 8'sd14,
    parameter logic signed [7:0] K2 = 8'sd14,
    parameter logic signed [7:0] K3 = 8'sd14,
    parameter logic signed [7:0] K4 = 8'sd14,
    parameter logic signed [7:0] K5 = 8'sd14,
    parameter logic signed [7:0] K6 = 8'sd14,
    parameter logic signed [7:0] K7 = 8'sd14,
    parameter logic signed [7:0] K8 = 8'sd14
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_st,
    input  logic signed [7:0] din,
    output logic signed [7:0] dout,
    output logic              out_st
);

    typedef enum logic [1:0] {IDLE, LOAD, CONV} state_t;

    localparam logic signed [7:0] KERN [9] = '{K0, K1, K2, K3, K4, K5, K6, K7, K8};

    state_t             state;
    state_t             state_nxt;
    logic               load_en;
    logic               conv_en;
    logic               last_out;

    logic signed [7:0]  frame [64];
    logic [5:0]         pix_cnt;
    logic [2:0]         out_row;
    logic [2:0]         out_col;

    logic [2:0]         win_row;
    logic [2:0]         win_col;
    logic signed [7:0]  pix;
    logic signed [15:0] prod;
    logic signed [19:0] acc_sum;
    logic signed [19:0] acc_q;
    logic               acc_vld;
    logic signed [12:0] res_wide;
    logic signed [7:0]  res_sat;

    assign last_out = (out_row == 3'd5) && (out_col == 3'd5);

    // FSM: state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // FSM: next-state logic
    always_comb begin
        // NOTE: default assignment first so every path drives state_nxt and no latch is inferred.
        state_nxt = state;
        unique case (state)
            IDLE: if (in_st) state_nxt = LOAD;
            LOAD: if (in_st && pix_cnt == 6'd63) state_nxt = CONV;
            CONV: if (last_out) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // FSM: outputs (pixels offered during CONV are dropped)
    always_comb begin
        load_en = in_st && (state != CONV);
        conv_en = (state == CONV);
    end

    // NOTE: the frame buffer has no reset; every load overwrites it before it is read.
    always_ff @(posedge clk) begin
        if (load_en) frame[pix_cnt] <= din;
    end

    // pix_cnt wraps 63 -> 0, so IDLE always writes pixel 0.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pix_cnt <= '0;
            out_row <= '0;
            out_col <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so all registers update together.
            if (load_en) pix_cnt <= pix_cnt + 6'd1;
            if (conv_en) begin
                if (out_col == 3'd5) begin
                    out_col <= '0;
                    out_row <= (out_row == 3'd5) ? 3'd0 : out_row + 3'd1;
                end else begin
                    out_col <= out_col + 3'd1;
                end
            end
        end
    end

    // Nine-tap multiply-accumulate over the window anchored at (out_row, out_col).
    always_comb begin
        acc_sum = '0;
        win_row = '0;
        win_col = '0;
        pix     = '0;
        prod    = '0;
        for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < 3; j++) begin
                win_row = out_row + 3'(i);
                win_col = out_col + 3'(j);
                pix     = frame[{win_row, win_col}];
                prod    = pix * KERN[i*3+j];
                acc_sum = acc_sum + 20'(prod);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc_q   <= '0;
            acc_vld <= 1'b0;
        end else begin
            acc_q   <= acc_sum;
            acc_vld <= conv_en;
        end
    end

    // Q2.14 sum back to Q1.7: arithmetic shift floors, then clamp.
    always_comb begin
        res_wide = 13'(acc_q >>> 7);
        if (res_wide > 13'sd127)       res_sat = 8'sd127;
        else if (res_wide < -13'sd128) res_sat = -8'sd128;
        else                           res_sat = res_wide[7:0];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_st <= 1'b0;
            dout   <= '0;
        end else begin
            out_st <= acc_vld;
            dout   <= acc_vld ? res_sat : 8'sd0;
        end
    end

endmodule

// File: tb/tb_module_conv.sv
// Directed bench for module_conv: table of whole-frame vectors plus reset corner sequences.
// A second instance with every tap at 127 exercises the positive saturation path.
module tb_module_conv;

    logic              clk = 1'b0;
    logic              reset;
    logic              in_st;
    logic signed [7:0] din;
    logic signed [7:0] dout;
    logic              out_st;
    logic signed [7:0] dout2;
    logic              out_st2;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    logic signed [7:0] q1 [$];
    logic signed [7:0] q2 [$];
    int                qc [$];

    typedef struct {
        string name;
        int    mode;      // 0: constant val, 1: ramp x[r][c] = 8r+c
        int    val;
        int    pause_at;  // pixel index after which in_st drops; -1 for none
        int    pause_len;
        int    exp_first;
        int    exp_last;
    } vec_t;

    vec_t vecs [5];

    module_conv dut (
        .clk(clk), .reset(reset), .in_st(in_st), .din(din),
        .dout(dout), .out_st(out_st)
    );

    module_conv #(
        .K0(8'sd127), .K1(8'sd127), .K2(8'sd127), .K3(8'sd127), .K4(8'sd127),
        .K5(8'sd127), .K6(8'sd127), .K7(8'sd127), .K8(8'sd127)
    ) dut_k127 (
        .clk(clk), .reset(reset), .in_st(in_st), .din(din),
        .dout(dout2), .out_st(out_st2)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (out_st) begin
            q1.push_back(dout);
            qc.push_back(cyc);
        end
        if (out_st2) q2.push_back(dout2);
    end

    task automatic check(input string name, input logic signed [31:0] act, input logic signed [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int model(input int mode, input int val, input int kern, input int k);
        int r, c, psum, y;
        r = k / 6;
        c = k % 6;
        psum = (mode == 1) ? 9 * (8 * (r + 1) + (c + 1)) : 9 * val;
        y = (kern * psum) >>> 7;
        if (y > 127)  y = 127;
        if (y < -128) y = -128;
        return y;
    endfunction

    task automatic clear_queues();
        q1.delete();
        q2.delete();
        qc.delete();
    endtask

    task automatic drive_frame(input vec_t v, output int start);
        start = 0;
        for (int p = 0; p < 64; p++) begin
            if (p == v.pause_at + 1) begin
                repeat (v.pause_len) begin
                    @(negedge clk);
                    in_st = 1'b0;
                end
            end
            @(negedge clk);
            in_st = 1'b1;
            din   = (v.mode == 1) ? 8'(p) : 8'(v.val);
            if (p == 0) start = cyc + 1;
        end
        @(negedge clk);
        in_st = 1'b0;
        din   = '0;
    endtask

    task automatic run_frame(input vec_t v);
        int start;
        clear_queues();
        drive_frame(v, start);
        repeat (45) @(negedge clk);
        #1;
        check({v.name, "_count"}, q1.size(), 36);
        check({v.name, "_count_k127"}, q2.size(), 36);
        if (q1.size() > 0) begin
            check({v.name, "_latency"}, qc[0] - start, 65 + v.pause_len);
            check({v.name, "_first"}, q1[0], v.exp_first);
        end
        if (q1.size() == 36) begin
            check({v.name, "_contiguous"}, qc[35] - qc[0], 35);
            check({v.name, "_last"}, q1[35], v.exp_last);
        end
        for (int k = 0; k < q1.size() && k < 36; k++)
            check($sformatf("%s_y%0d", v.name, k), q1[k], model(v.mode, v.val, 14, k));
        for (int k = 0; k < q2.size() && k < 36; k++)
            check($sformatf("%s_k127_y%0d", v.name, k), q2[k], model(v.mode, v.val, 127, k));
        check({v.name, "_idle_out_st"}, out_st, 1'b0);
        check({v.name, "_idle_dout"}, dout, 0);
    endtask

    initial begin
        int start;
        vecs[0] = '{"const64", 0,   64, -1, 0,   63,   63};
        vecs[1] = '{"ramp",    1,    0, -1, 0,    8,   53};
        vecs[2] = '{"neg128",  0, -128, -1, 0, -126, -126};
        vecs[3] = '{"pos127",  0,  127, -1, 0,  125,  125};
        vecs[4] = '{"paused",  0,   64, 20, 5,   63,   63};

        reset = 1'b1;
        in_st = 1'b0;
        din   = '0;
        #3;
        check("reset_out_st", out_st, 1'b0);
        check("reset_dout", dout, 0);
        check("reset_out_st_k127", out_st2, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        clear_queues();
        repeat (10) @(negedge clk);
        #1;
        check("reset_quiet", q1.size(), 0);

        for (int n = 0; n < 5; n++) run_frame(vecs[n]);

        // Abort a frame after its 10th output with an asynchronous reset.
        clear_queues();
        drive_frame(vecs[0], start);
        for (int n = 0; n < 45; n++) begin
            @(negedge clk);
            #1;
            if (q1.size() >= 10) break;
        end
        check("abort_reached_10", q1.size(), 10);
        #2;
        reset = 1'b1;
        #1;
        check("abort_out_st", out_st, 1'b0);
        check("abort_dout", dout, 0);
        @(negedge clk);
        reset = 1'b0;
        clear_queues();
        repeat (40) @(negedge clk);
        #1;
        check("abort_quiet", q1.size(), 0);
        run_frame(vecs[0]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
